// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction-timer controller: state encoding,
// LFSR constants and default timebase rates.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GO    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_TICK_HZ = 100;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Player-button inputs and display-side outputs of the reaction-timer controller.
interface reaction_timer_ctrl_if;
  logic        start;
  logic        stop;
  logic        led;
  logic        busy;
  logic [13:0] result;
  logic        result_valid;
  logic        early;
  logic        timeout;

  modport master (
    output start, stop,
    input  led, busy, result, result_valid, early, timeout
  );

  modport slave (
    input  start, stop,
    output led, busy, result, result_valid, early, timeout
  );
endinterface

// File: rtl/reaction_timer_ctrl_tick_gen.sv
// Timebase: one-cycle tick enable every CLK_HZ/TICK_HZ clocks, restartable so
// a measurement window always begins on a full tick period.
module tick_gen
  import reaction_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: CLK_HZ must be at least TICK_HZ");
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random hold-off, GO lamp, centisecond count until
// stop, with false-start and timeout reporting. All outputs are registered.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_HZ    = DEFAULT_CLK_HZ,
  parameter int TICK_HZ   = DEFAULT_TICK_HZ,
  parameter int MIN_DELAY = 200,
  parameter int MAX_COUNT = 9999
) (
  input logic                 clk,
  input logic                 reset,
  reaction_timer_ctrl_if.slave bus
);

  if (MAX_COUNT < 1 || MAX_COUNT > 16383) begin : g_bad_max
    $error("reaction_timer_ctrl: MAX_COUNT must fit in 14 bits");
  end
  if (MIN_DELAY < 1 || MIN_DELAY + 255 >= 1024) begin : g_bad_delay
    $error("reaction_timer_ctrl: MIN_DELAY+255 must fit in 10 bits");
  end

  localparam logic [13:0] MAXC  = 14'(MAX_COUNT);
  localparam logic [9:0]  MIN_D = 10'(MIN_DELAY);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [9:0]  r_delay;
  logic [13:0] r_count;
  logic [13:0] r_result;
  logic        r_led;
  logic        r_busy;
  logic        r_valid;
  logic        r_early;
  logic        r_timeout;

  logic w_tick;
  logic w_accept;
  logic w_go;

  assign w_accept = bus.start &&
                    (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FAULT);
  // A stop on the final hold-off tick is a false start, so it blocks the GO transition.
  assign w_go     = (r_state == ST_WAIT) && w_tick && (r_delay == 10'd1) && !bus.stop;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(w_accept || w_go),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_delay   <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (bus.start) begin
            r_state   <= ST_WAIT;
            r_busy    <= 1'b1;
            r_delay   <= MIN_D + {2'b00, r_lfsr[7:0]};
            r_valid   <= 1'b0;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.stop) begin
            r_state <= ST_FAULT;
            r_early <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_tick) begin
            if (r_delay == 10'd1) begin
              r_state <= ST_GO;
              r_led   <= 1'b1;
              r_count <= '0;
            end else begin
              r_delay <= r_delay - 10'd1;
            end
          end
        end
        ST_GO: begin
          if (bus.stop) begin
            r_state  <= ST_DONE;
            r_result <= r_count;
            r_valid  <= 1'b1;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_tick) begin
            if (r_count == MAXC - 14'd1) begin
              r_state   <= ST_DONE;
              r_count   <= MAXC;
              r_result  <= MAXC;
              r_timeout <= 1'b1;
              r_valid   <= 1'b1;
              r_led     <= 1'b0;
              r_busy    <= 1'b0;
            end else begin
              r_count <= r_count + 14'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led          = r_led;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;
  assign bus.early        = r_early;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl at DIV=10, MIN_DELAY=2, MAX_COUNT=20:
// trials push their expected outcome; a monitor checks each trial as busy falls.
module tb_reaction_timer_ctrl;
  import reaction_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int MIN_DELAY = 2;
  localparam int MAX_COUNT = 20;
  localparam int LED_BOUND = DIV * (MIN_DELAY + 256) + 20;
  localparam int END_BOUND = DIV * MAX_COUNT + 20;

  localparam int M_REACT = 0;
  localparam int M_EARLY = 1;
  localparam int M_TMO   = 2;
  localparam int M_RST   = 3;

  typedef struct {
    int          led_off;
    int          end_off;
    logic [13:0] result;
    logic        valid;
    logic        early;
    logic        timeout;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic [15:0] m_lfsr;
  logic [13:0] last_result = '0;
  exp_t sb[$];

  reaction_timer_ctrl_if bus ();

  reaction_timer_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .MIN_DELAY(MIN_DELAY),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden LFSR: x^16+x^14+x^13+x^11+1, shifting right, feedback into bit 15.
  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : model_next(m_lfsr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: trial start on busy rise, lamp on led rise, verdict on busy fall.
  initial begin
    logic prev_busy, prev_led;
    int   c0, led_off;
    exp_t e;
    prev_busy = 1'b0;
    prev_led  = 1'b0;
    c0        = 0;
    led_off   = -1;
    forever begin
      @(negedge clk);
      if (bus.busy && !prev_busy) begin
        c0      = cyc;
        led_off = -1;
        check("entry_flags", {bus.led, bus.result_valid, bus.early, bus.timeout}, 0);
      end
      if (bus.led && !prev_led) led_off = cyc - c0;
      if (!bus.busy && prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_trial_end", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("trial end: led_off=%0d end_off=%0d result=%0d valid=%0b early=%0b timeout=%0b",
                   led_off, cyc - c0, bus.result, bus.result_valid, bus.early, bus.timeout);
          check("led_rise_offset", led_off, e.led_off);
          check("end_offset", cyc - c0, e.end_off);
          check("result", bus.result, e.result);
          check("result_valid", bus.result_valid, e.valid);
          check("early", bus.early, e.early);
          check("timeout", bus.timeout, e.timeout);
          check("led_off_at_end", bus.led, 0);
        end
      end
      prev_busy = bus.busy;
      prev_led  = bus.led;
    end
  end

  task automatic pulse_start(input bit with_stop);
    bus.start = 1'b1;
    bus.stop  = with_stop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic wait_led();
    int n;
    n = 0;
    while (!bus.led && n < LED_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.led) check("led_wait_expired", 0, 1);
  endtask

  // k: mode-dependent offset; 0 = random, -1 (false start) = final hold-off tick.
  task automatic run_trial(input int mode, input int k_in, input bit both);
    exp_t e;
    int   d, k, n;
    d = MIN_DELAY + int'(m_lfsr[7:0]);
    k = k_in;
    case (mode)
      M_EARLY: if (k == 0) k = $urandom_range(DIV * d, 1); else if (k < 0) k = DIV * d;
      M_RST:   if (k == 0) k = $urandom_range(DIV * MAX_COUNT - 1, 1);
      default: if (k == 0) k = $urandom_range(DIV * MAX_COUNT, 1);
    endcase
    e.led_off = DIV * d;
    e.early   = 1'b0;
    e.timeout = 1'b0;
    e.valid   = 1'b1;
    case (mode)
      M_REACT: begin
        e.end_off = DIV * d + k;
        e.result  = 14'((k - 1) / DIV);
      end
      M_EARLY: begin
        e.led_off = -1;
        e.end_off = k;
        e.result  = last_result;
        e.valid   = 1'b0;
        e.early   = 1'b1;
      end
      M_TMO: begin
        e.end_off = DIV * d + DIV * MAX_COUNT;
        e.result  = 14'(MAX_COUNT);
        e.timeout = 1'b1;
      end
      default: begin
        e.end_off = DIV * d + k;
        e.result  = '0;
        e.valid   = 1'b0;
      end
    endcase
    last_result = e.result;
    $display("trial: mode=%0d delay=%0d k=%0d start_with_stop=%0b expect result=%0d",
             mode, d, k, both, e.result);
    sb.push_back(e);
    pulse_start(both);
    if (mode == M_EARLY) begin
      repeat (k - 1) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
    end else begin
      if (mode == M_REACT) begin
        @(negedge clk);
        pulse_start(1'b0);
      end
      wait_led();
      if (mode != M_TMO) begin
        repeat (k - 1) @(negedge clk);
        if (mode == M_RST) reset = 1'b1;
        else bus.stop = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        bus.stop = 1'b0;
      end
    end
    n = 0;
    while (bus.busy && n < END_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("end_wait_expired", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.led, bus.busy, bus.result_valid, bus.early, bus.timeout, bus.result}, 0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", {bus.led, bus.busy, bus.result_valid, bus.early, bus.timeout, bus.result}, 0);
      check("idle_lfsr", dut.r_lfsr, m_lfsr);
      check("idle_state", dut.r_state, ST_IDLE);
    end

    run_trial(M_REACT, 57, 1'b0);
    run_trial(M_EARLY, 5, 1'b0);
    run_trial(M_REACT, 30, 1'b0);
    run_trial(M_TMO, 0, 1'b0);
    run_trial(M_REACT, 40, 1'b0);
    run_trial(M_REACT, 25, 1'b1);
    run_trial(M_EARLY, -1, 1'b0);
    run_trial(M_REACT, DIV * MAX_COUNT, 1'b0);
    run_trial(M_RST, 75, 1'b0);
    run_trial(M_REACT, 57, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_trial(int'($urandom_range(3, 0)), 0, 1'($urandom_range(1, 0)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Sequencing controller for the reaction-timer lab design. It owns the 100 Hz timebase as a single-cycle tick enable in the system clock domain, not a derived clock. It runs the trial sequence: a random hold-off delay, then LED on, then a centisecond count until the player presses stop. It reports the reaction time, a false-start flag, or a timeout to the display logic.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency
- TICK_HZ, 100, timebase rate; DIV = CLK_HZ/TICK_HZ clocks per tick
- MIN_DELAY, 200, minimum hold-off in ticks (2.00 s)
- MAX_COUNT, 9999, reaction count ceiling in ticks

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, already debounced and synchronized upstream
- stop  in  1  one-cycle pulse, already debounced and synchronized upstream
- led  out  1  "GO" lamp
- busy  out  1  high in WAIT and GO
- result  out  14  reaction time in centiseconds
- result_valid  out  1  result holds a completed measurement
- early  out  1  false start detected
- timeout  out  1  count reached MAX_COUNT

## Operation
- States:
  - IDLE: start -> WAIT.
  - WAIT: on entry, load delay = MIN_DELAY + lfsr[7:0] and clear result_valid, early and timeout. Decrement delay on each tick. stop -> FAULT with early=1. When a tick arrives with delay==1 -> GO. start is ignored.
  - GO: on entry, led=1 and count=0. Increment count on each tick. stop -> DONE with result=count, result_valid=1, led=0. A tick that makes count==MAX_COUNT -> DONE with result=MAX_COUNT, timeout=1, result_valid=1, led=0. start is ignored.
  - DONE: outputs are held. start -> WAIT.
  - FAULT: early is held. start -> WAIT, which clears early.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Advances every clk cycle, including during reset release. Never all-zero.
- Tick counter:
  - Runs 0..DIV-1; tick is high for one cycle when it equals DIV-1.
  - Forced to 0 on the cycle start is accepted and on the WAIT->GO transition, so every measured centisecond is a full DIV cycles.
- Simultaneous events:
  - start & stop in IDLE/DONE/FAULT: start wins -> WAIT.
  - stop & final tick in WAIT: stop wins -> FAULT.
  - stop & tick in GO: stop wins; count is not incremented.
- reset in any state, including mid-GO: all registers return to their reset values next edge; no partial result is reported.
- Width rules:
  - count and result are 14 bits (MAX_COUNT ≤ 16383, checked at elaboration).
  - delay is 10 bits (MIN_DELAY+255 < 1024).

## Timing
- Reset values:
  - state IDLE, led 0, busy 0.
  - result 0, result_valid 0, early 0, timeout 0.
  - tick counter 0, LFSR 16'hACE1.
- All outputs are registered.
- start -> busy=1: 1 cycle.
- Final WAIT tick -> led=1: 1 cycle.
- stop -> led=0, result_valid=1, result updated: 1 cycle.
- Reaction resolution: 1 tick. Result = floor((cycles from led rise to stop)/DIV).

## Structure
- Shared package reaction_pkg:
  - state encoding (IDLE, WAIT, GO, DONE, FAULT)
  - LFSR seed and tap mask
  - default CLK_HZ/TICK_HZ
- One sub-module, tick_gen:
  - params CLK_HZ, TICK_HZ
  - ports clk, reset, restart, tick
  - A single-domain replacement for the old divided-clock approach.
- The FSM, delay counter, reaction counter and LFSR live in reaction_timer_ctrl.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), MIN_DELAY=2, MAX_COUNT=20.
- Reset, then 50 idle cycles: all outputs 0, state IDLE, LFSR sequence matches the golden model from 16'hACE1.
- Normal trial: start, wait for led=1, stop 57 cycles later -> result=5, result_valid=1, led=0, busy=0 the next cycle.
- False start: start, then stop 5 cycles later -> early=1, led never rises, result_valid=0. A following start clears early and enters WAIT.
- Timeout: start, no stop -> exactly 200 cycles after led=1, result=20, timeout=1, led=0.
- Stop coincident with a GO tick at count=3 -> result=3. Start and stop in the same cycle in DONE -> WAIT, result_valid cleared.
- Reset asserted mid-GO at count=7 -> next cycle all outputs are at reset values; a later trial measures correctly.
